// File: rtl/arm_mem_pkg.sv
// Shared types and widths for the ARM memory responder and its program loader.
package arm_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RUN   = 2'd3
  } ld_state_e;

endpackage

// File: rtl/arm_mem_loader.sv
// Program loader: assembles little-endian image bytes into words, writes them into
// instruction memory and holds the core in reset until the image is complete.
module mem_loader
  import arm_mem_pkg::*;
#(
  parameter int IMEM_AW       = 6,
  parameter bit LOAD_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [BYTE_W-1:0]  ld_byte,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               ld_overflow,
  output logic               core_reset,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [WORD_W-1:0]  imem_wdata,
  output ld_state_e          dbg_state,
  output logic [1:0]         dbg_byte_cnt
);

  localparam ld_state_e RESET_STATE = LOAD_ON_RESET ? ST_IDLE : ST_RUN;

  ld_state_e           state_q;
  logic [1:0]          byte_cnt_q;
  logic [IMEM_AW:0]    waddr_q;      // extra MSB marks "memory full"; saturates there
  logic [WORD_W-1:0]   buf_q;
  logic                last_q;
  logic                overflow_q;

  logic accept;
  logic room;

  // Handshake: a byte transfers when ld_valid && ld_ready at a rising edge;
  // ld_start in the same cycle wins and the byte is not taken.
  assign accept = ld_valid && (state_q == ST_LOAD) && !ld_start;
  assign room   = !waddr_q[IMEM_AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      byte_cnt_q <= '0;
      waddr_q    <= '0;
      buf_q      <= '0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (ld_start) begin
      state_q    <= ST_LOAD;
      byte_cnt_q <= '0;
      waddr_q    <= '0;
      buf_q      <= '0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            buf_q[{byte_cnt_q, 3'b000} +: BYTE_W] <= ld_byte;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3 || ld_last) begin
              state_q <= ST_WRITE;
              last_q  <= ld_last;
            end
          end
        end
        ST_WRITE: begin
          if (room) begin
            waddr_q <= waddr_q + 1'b1;
          end else begin
            overflow_q <= 1'b1;
          end
          buf_q      <= '0;
          byte_cnt_q <= '0;
          state_q    <= last_q ? ST_RUN : ST_LOAD;
        end
        default: ;
      endcase
    end
  end

  assign ld_ready     = (state_q == ST_LOAD);
  assign ld_overflow  = overflow_q;
  assign core_reset   = !rst_n || (state_q != ST_RUN);
  assign imem_we      = (state_q == ST_WRITE) && room && !ld_start;
  assign imem_waddr   = waddr_q[IMEM_AW-1:0];
  assign imem_wdata   = buf_q;
  assign dbg_state    = state_q;
  assign dbg_byte_cnt = byte_cnt_q;

endmodule

// File: rtl/arm_mem_system.sv
// Memory-side responder for the single-cycle ARM core: combinational instruction and
// data reads, clocked stores, and the program loader that fills instruction memory.
module arm_mem_system
  import arm_mem_pkg::*;
#(
  parameter int IMEM_AW       = 6,
  parameter int DMEM_AW       = 6,
  parameter bit LOAD_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WORD_W-1:0]  pc,
  output logic [WORD_W-1:0]  instr,
  input  logic [WORD_W-1:0]  alu_result,
  input  logic [WORD_W-1:0]  write_data,
  input  logic               mem_write,
  output logic [WORD_W-1:0]  read_data,
  output logic               core_reset,
  input  logic               ld_start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [BYTE_W-1:0]  ld_byte,
  input  logic               ld_last,
  output logic               ld_overflow,
  output logic [1:0]         dbg_state,
  output logic [1:0]         dbg_byte_cnt
);

  logic [WORD_W-1:0] imem [2**IMEM_AW];
  logic [WORD_W-1:0] dmem [2**DMEM_AW];

  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [WORD_W-1:0]  imem_wdata;
  ld_state_e          state;

  logic pc_in_range;
  logic da_in_range;
  logic dmem_we;
  logic unused_byte_offsets;

  mem_loader #(
    .IMEM_AW       (IMEM_AW),
    .LOAD_ON_RESET (LOAD_ON_RESET)
  ) u_loader (
    .clk          (clk),
    .rst_n        (reset),
    .ld_start     (ld_start),
    .ld_valid     (ld_valid),
    .ld_byte      (ld_byte),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .ld_overflow  (ld_overflow),
    .core_reset   (core_reset),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .dbg_state    (state),
    .dbg_byte_cnt (dbg_byte_cnt)
  );

  assign dbg_state = state;

  // Any address bit above the array range makes the access miss: reads return 0, stores drop.
  assign pc_in_range = (pc[WORD_W-1:IMEM_AW+2] == '0);
  assign da_in_range = (alu_result[WORD_W-1:DMEM_AW+2] == '0);
  assign dmem_we     = mem_write && !core_reset && da_in_range;

  assign unused_byte_offsets = ^{pc[1:0], alu_result[1:0]};

  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (dmem_we) begin
      dmem[alu_result[DMEM_AW+1:2]] <= write_data;
    end
  end

  assign instr     = pc_in_range ? imem[pc[IMEM_AW+1:2]] : '0;
  assign read_data = da_in_range ? dmem[alu_result[DMEM_AW+1:2]] : '0;

endmodule
